frog_key_decoder: RTL and testbench

//  PS/2 keyboard front end that produces the level-held up/down/left/right

---
 rtl/frog_pkg.sv | 51 +++++
 rtl/ps2_rx.sv | 105 ++++++++++
 rtl/frog_key_decoder.sv | 99 +++++++++
 tb/tb_frog_key_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared scan codes, prefix states and direction payload for the frog PS/2 key decoder.
package frog_pkg;

  localparam int unsigned CODE_W = 8;

  localparam logic [CODE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [CODE_W-1:0] SC_BRK   = 8'hF0;
  localparam logic [CODE_W-1:0] SC_UP    = 8'h75;
  localparam logic [CODE_W-1:0] SC_DOWN  = 8'h72;
  localparam logic [CODE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [CODE_W-1:0] SC_RIGHT = 8'h74;
  localparam logic [CODE_W-1:0] SC_W     = 8'h1D;
  localparam logic [CODE_W-1:0] SC_S     = 8'h1B;
  localparam logic [CODE_W-1:0] SC_A     = 8'h1C;
  localparam logic [CODE_W-1:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXT_BRK} prefix_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Direction bit addressed by a scan code; arrows need the E0 prefix, WASD must not have it.
  function automatic dir_t key_mask(input logic [CODE_W-1:0] code, input logic ext,
                                    input logic wasd);
    dir_t m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:    m.up    = 1'b1;
        SC_DOWN:  m.down  = 1'b1;
        SC_LEFT:  m.left  = 1'b1;
        SC_RIGHT: m.right = 1'b1;
        default:  m = '0;
      endcase
    end else if (wasd) begin
      case (code)
        SC_W:    m.up    = 1'b1;
        SC_S:    m.down  = 1'b1;
        SC_A:    m.left  = 1'b1;
        SC_D:    m.right = 1'b1;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge sampling, frame checks and
// a mid-frame idle timeout. Outputs are registered one cycle after the 11th sample.
module ps2_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned TMO_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = 10;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [FRAME_W-1:0]     shreg_q, shreg_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic clk_s;
  logic data_s;
  logic fall;
  logic frame_ok;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // shreg_q holds start in [0], D0..D7 in [8:1], parity in [9]; stop is the live sample.
  assign frame_ok = ~shreg_q[0] & (^shreg_q[9:1]) & data_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      tmo_q       <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tmo_d    = tmo_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (bitcnt_q == CNT_W'(FRAME_W)) begin
        bitcnt_d = '0;
        if (frame_ok) begin
          valid_d = 1'b1;
          byte_d  = shreg_q[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        shreg_d  = {data_s, shreg_q[FRAME_W-1:1]};
        bitcnt_d = bitcnt_q + CNT_W'(1);
      end
    end else if (bitcnt_q != '0) begin
      // Stalled mid-frame: abort so the next start bit realigns the receiver.
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        bitcnt_d = '0;
        tmo_d    = '0;
        err_d    = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/frog_key_decoder.sv
// PS/2 keyboard front end: decodes E0/F0 prefixed scan codes into level-held
// up/down/left/right bits for the frog movement logic.
module frog_key_decoder
  import frog_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter bit          ENABLE_WASD = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [7:0] keycode,
  output logic       code_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  prefix_t prefix_q, prefix_d;
  dir_t    dir_q, dir_d;

  ps2_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk     (Clk),
    .rst     (Reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prefix_q <= P_IDLE;
      dir_q    <= '0;
    end else begin
      prefix_q <= prefix_d;
      dir_q    <= dir_d;
    end
  end

  // Prefix tracking; direction bits only move on a complete make or break sequence.
  always_comb begin
    prefix_d = prefix_q;
    dir_d    = dir_q;
    if (rx_err) begin
      prefix_d = P_IDLE;
    end else if (rx_valid) begin
      case (prefix_q)
        P_IDLE: begin
          if (rx_byte == SC_EXT) begin
            prefix_d = P_EXT;
          end else if (rx_byte == SC_BRK) begin
            prefix_d = P_BRK;
          end else begin
            dir_d = dir_q | key_mask(rx_byte, 1'b0, ENABLE_WASD);
          end
        end
        P_EXT: begin
          if (rx_byte == SC_BRK) begin
            prefix_d = P_EXT_BRK;
          end else if (rx_byte != SC_EXT) begin
            dir_d    = dir_q | key_mask(rx_byte, 1'b1, ENABLE_WASD);
            prefix_d = P_IDLE;
          end
        end
        P_BRK: begin
          dir_d    = dir_q & ~key_mask(rx_byte, 1'b0, ENABLE_WASD);
          prefix_d = P_IDLE;
        end
        P_EXT_BRK: begin
          dir_d    = dir_q & ~key_mask(rx_byte, 1'b1, ENABLE_WASD);
          prefix_d = P_IDLE;
        end
        default: prefix_d = P_IDLE;
      endcase
    end
  end

  assign up         = dir_q.up;
  assign down       = dir_q.down;
  assign left       = dir_q.left;
  assign right      = dir_q.right;
  assign keycode    = rx_byte;
  assign code_valid = rx_valid;
  assign frame_err  = rx_err;

endmodule

// File: tb/tb_frog_key_decoder.sv
// Directed bench: two decoders (WASD on/off) share one PS/2 line; table of frames plus
// hand-written timeout and reset-mid-frame sequences.
module tb_frog_key_decoder;

  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 6;

  typedef struct {
    logic [7:0] code;
    logic       bad;
    logic [3:0] dir0;
    logic [3:0] dir1;
    logic [7:0] kc;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  logic ps2_clk;
  logic ps2_data;

  logic       up0, down0, left0, right0, cv0, fe0;
  logic [7:0] kc0;
  logic       up1, down1, left1, right1, cv1, fe1;
  logic [7:0] kc1;

  int checks = 0;
  int errors = 0;
  int cv_cnt0 = 0, fe_cnt0 = 0, cv_cnt1 = 0, fe_cnt1 = 0;
  int exp_cv = 0, exp_fe = 0;

  vec_t vecs[$];

  frog_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYC(TMO), .ENABLE_WASD(1'b1)) dut0 (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up0), .down(down0), .left(left0), .right(right0),
    .keycode(kc0), .code_valid(cv0), .frame_err(fe0)
  );

  frog_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYC(TMO), .ENABLE_WASD(1'b0)) dut1 (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up1), .down(down1), .left(left1), .right(right1),
    .keycode(kc1), .code_valid(cv1), .frame_err(fe1)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (cv0) cv_cnt0++;
    if (fe0) fe_cnt0++;
    if (cv1) cv_cnt1++;
    if (fe1) fe_cnt1++;
  end

  function automatic logic [3:0] dir0();
    return {up0, down0, left0, right0};
  endfunction

  function automatic logic [3:0] dir1();
    return {up1, down1, left1, right1};
  endfunction

  function automatic vec_t mk(input logic [7:0] c, input logic b, input logic [3:0] d0,
                              input logic [3:0] d1, input logic [7:0] k);
    vec_t v;
    v.code = c; v.bad = b; v.dir0 = d0; v.dir1 = d1; v.kc = k;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives the first nbits of a frame; returns with ps2_clk low after the last falling edge.
  task automatic send_bits(input logic [7:0] code, input logic bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge Clk);
      ps2_clk = 1'b0;
      if (i != nbits - 1) begin
        repeat (HALF) @(posedge Clk);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic release_clk();
    ps2_clk = 1'b1;
    repeat (HALF) @(posedge Clk);
  endtask

  task automatic do_frame(input vec_t v, input string tag);
    logic [3:0] before0, before1;
    bit got;
    before0 = dir0();
    before1 = dir1();
    send_bits(v.code, v.bad, 11);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge Clk);
      if (cv0 || fe0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_no_event: got none expected code_valid/frame_err", tag);
    end else begin
      check({tag, "_err"}, 32'(fe0), 32'(v.bad));
      check({tag, "_cv"}, 32'(cv0), 32'(!v.bad));
      check({tag, "_dir0_hold"}, 32'(dir0()), 32'(before0));
      check({tag, "_dir1_hold"}, 32'(dir1()), 32'(before1));
      @(negedge Clk);
      check({tag, "_dir0"}, 32'(dir0()), 32'(v.dir0));
      check({tag, "_dir1"}, 32'(dir1()), 32'(v.dir1));
      check({tag, "_kc0"}, 32'(kc0), 32'(v.kc));
      check({tag, "_kc1"}, 32'(kc1), 32'(v.kc));
    end
    if (v.bad) exp_fe++; else exp_cv++;
    release_clk();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dir0"}, 32'(dir0()), 32'h0);
    check({tag, "_dir1"}, 32'(dir1()), 32'h0);
    check({tag, "_kc0"}, 32'(kc0), 32'h0);
    check({tag, "_pulses"}, 32'({cv0, fe0, cv1, fe1}), 32'h0);
  endtask

  initial begin : main
    bit got;
    Reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b0;
    repeat (4) @(negedge Clk);

    // dir columns are {up, down, left, right}; dir1 is the arrow-only instance
    vecs.push_back(mk(8'hE0, 0, 4'b0000, 4'b0000, 8'hE0));
    vecs.push_back(mk(8'h75, 0, 4'b1000, 4'b1000, 8'h75));
    vecs.push_back(mk(8'hE0, 0, 4'b1000, 4'b1000, 8'hE0));
    vecs.push_back(mk(8'hF0, 0, 4'b1000, 4'b1000, 8'hF0));
    vecs.push_back(mk(8'h75, 0, 4'b0000, 4'b0000, 8'h75));
    vecs.push_back(mk(8'hE0, 0, 4'b0000, 4'b0000, 8'hE0));
    vecs.push_back(mk(8'h6B, 0, 4'b0010, 4'b0010, 8'h6B));
    vecs.push_back(mk(8'hE0, 0, 4'b0010, 4'b0010, 8'hE0));
    vecs.push_back(mk(8'h74, 0, 4'b0011, 4'b0011, 8'h74));
    vecs.push_back(mk(8'hE0, 0, 4'b0011, 4'b0011, 8'hE0));
    vecs.push_back(mk(8'hF0, 0, 4'b0011, 4'b0011, 8'hF0));
    vecs.push_back(mk(8'h6B, 0, 4'b0001, 4'b0001, 8'h6B));
    vecs.push_back(mk(8'h1D, 1, 4'b0001, 4'b0001, 8'h6B));
    vecs.push_back(mk(8'h1D, 0, 4'b1001, 4'b0001, 8'h1D));
    for (int r = 0; r < 3; r++) begin
      vecs.push_back(mk(8'hE0, 0, 4'b1101 & ({4{r != 0}} | 4'b1001),
                        4'b0101 & ({4{r != 0}} | 4'b0001), 8'hE0));
      vecs.push_back(mk(8'h72, 0, 4'b1101, 4'b0101, 8'h72));
    end
    vecs.push_back(mk(8'hF0, 0, 4'b1101, 4'b0101, 8'hF0));
    vecs.push_back(mk(8'h1D, 0, 4'b0101, 4'b0101, 8'h1D));
    vecs.push_back(mk(8'hF0, 0, 4'b0101, 4'b0101, 8'hF0));
    vecs.push_back(mk(8'h1B, 0, 4'b0001, 4'b0101, 8'h1B));
    vecs.push_back(mk(8'hE0, 0, 4'b0001, 4'b0101, 8'hE0));
    vecs.push_back(mk(8'h11, 1, 4'b0001, 4'b0101, 8'hE0));
    vecs.push_back(mk(8'h74, 0, 4'b0001, 4'b0101, 8'h74));
    vecs.push_back(mk(8'hE0, 0, 4'b0001, 4'b0101, 8'hE0));
    vecs.push_back(mk(8'hF0, 0, 4'b0001, 4'b0101, 8'hF0));
    vecs.push_back(mk(8'h74, 0, 4'b0000, 4'b0100, 8'h74));
    vecs.push_back(mk(8'hF0, 0, 4'b0000, 4'b0100, 8'hF0));
    vecs.push_back(mk(8'h23, 0, 4'b0000, 4'b0100, 8'h23));
    vecs.push_back(mk(8'hE0, 0, 4'b0000, 4'b0100, 8'hE0));
    vecs.push_back(mk(8'hF0, 0, 4'b0000, 4'b0100, 8'hF0));
    vecs.push_back(mk(8'h72, 0, 4'b0000, 4'b0000, 8'h72));
    vecs.push_back(mk(8'h1D, 0, 4'b1000, 4'b0000, 8'h1D));
    vecs.push_back(mk(8'hF0, 0, 4'b1000, 4'b0000, 8'hF0));
    vecs.push_back(mk(8'h1D, 0, 4'b0000, 4'b0000, 8'h1D));

    for (int i = 0; i < vecs.size(); i++) begin
      do_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Stalled frame: six falling edges then silence must abort with frame_err.
    send_bits(8'h1C, 1'b0, 6);
    release_clk();
    got = 1'b0;
    for (int c = 0; c < int'(TMO) + 40 && !got; c++) begin
      @(negedge Clk);
      if (fe0) got = 1'b1;
    end
    check("timeout_err", 32'(got), 32'h1);
    check("timeout_kc", 32'(kc0), 32'h1D);
    exp_fe++;
    do_frame(mk(8'h1C, 0, 4'b0010, 4'b0000, 8'h1C), "after_tmo");
    do_frame(mk(8'hF0, 0, 4'b0010, 4'b0000, 8'hF0), "after_tmo_f0");
    do_frame(mk(8'h1C, 0, 4'b0000, 4'b0000, 8'h1C), "after_tmo_brk");

    // Reset during a partial frame, then reception resumes cleanly.
    do_frame(mk(8'hE0, 0, 4'b0000, 4'b0000, 8'hE0), "pre_rst_e0");
    do_frame(mk(8'h72, 0, 4'b0100, 4'b0100, 8'h72), "pre_rst_72");
    send_bits(8'h35, 1'b0, 5);
    release_clk();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check_all_zero("mid_rst");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    do_frame(mk(8'hE0, 0, 4'b0000, 4'b0000, 8'hE0), "post_rst_e0");
    do_frame(mk(8'h72, 0, 4'b0100, 4'b0100, 8'h72), "post_rst_72");

    repeat (5) @(negedge Clk);
    check("cv_count0", 32'(cv_cnt0), 32'(exp_cv));
    check("fe_count0", 32'(fe_cnt0), 32'(exp_fe));
    check("cv_count1", 32'(cv_cnt1), 32'(exp_cv));
    check("fe_count1", 32'(fe_cnt1), 32'(exp_fe));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
